// File: rtl/ex_issue_stage_pkg.sv
// Shared ALU opcode encoding and ID->EX operand-select encodings.
// Imported by the issue stage and its forwarding selector.
package ex_issue_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLT = 4'd6,
    OP_BEQ = 4'd8,
    OP_BNE = 4'd9,
    OP_BLT = 4'd10
  } alu_op_e;

  typedef enum logic {
    A_SEL_RK  = 1'b0,
    A_SEL_IMM = 1'b1
  } a_sel_e;

  typedef enum logic {
    B_SEL_RJ = 1'b0,
    B_SEL_PC = 1'b1
  } b_sel_e;

endpackage

// File: rtl/ex_fwd_sel.sv
// One source-operand forwarding selector: MEM result beats WB result beats
// register-file data, and r0 always reads as zero.
module ex_fwd_sel #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic [RIDX-1:0] idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_wen,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_wen,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rf_data;
    if (idx == '0) begin
      value = '0;
    end else if (exm_wen && (exm_rd == idx)) begin
      value = exm_data;
    end else if (mwb_wen && (mwb_rd == idx)) begin
      value = mwb_data;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX pipeline register with operand forwarding, ALU operand drive,
// branch redirect/ID flush and the load-use bubble.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rj_data,
  input  logic [XLEN-1:0] id_rk_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RIDX-1:0] id_rj,
  input  logic [RIDX-1:0] id_rk,
  input  logic [RIDX-1:0] id_rd,
  input  logic            id_use_rj,
  input  logic            id_use_rk,
  input  logic [3:0]      id_alu_op,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_wen,
  input  logic            id_is_load,
  input  logic            id_is_branch,
  input  logic            ex_stall,
  input  logic            exm_wen,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_wen,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic            alu_f,
  output logic            ex_valid,
  output logic            ex_wen,
  output logic            ex_is_load,
  output logic [RIDX-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            id_flush
);

  logic            ex_valid_reg;
  logic [XLEN-1:0] ex_pc_reg;
  logic [XLEN-1:0] ex_imm_reg;
  logic [XLEN-1:0] ex_rj_data_reg;
  logic [XLEN-1:0] ex_rk_data_reg;
  logic [RIDX-1:0] ex_rj_reg;
  logic [RIDX-1:0] ex_rk_reg;
  logic [RIDX-1:0] ex_rd_reg;
  logic [3:0]      ex_op_reg;
  a_sel_e          ex_a_sel_reg;
  b_sel_e          ex_b_sel_reg;
  logic            ex_wen_reg;
  logic            ex_is_load_reg;
  logic            ex_is_branch_reg;

  logic [XLEN-1:0] fwd_rj;
  logic [XLEN-1:0] fwd_rk;
  logic            hz;
  logic            take;

  ex_fwd_sel #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rj (
    .idx(ex_rj_reg), .rf_data(ex_rj_data_reg),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .value(fwd_rj)
  );

  ex_fwd_sel #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rk (
    .idx(ex_rk_reg), .rf_data(ex_rk_data_reg),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .value(fwd_rk)
  );

  // A load in EX delivers its data on exm_data next cycle, so one bubble covers it.
  assign hz = ex_valid_reg && ex_is_load_reg && ex_wen_reg && (ex_rd_reg != '0) && id_valid &&
              ((id_use_rj && (id_rj == ex_rd_reg)) || (id_use_rk && (id_rk == ex_rd_reg)));

  assign take = ex_valid_reg && ex_is_branch_reg && alu_f && !ex_stall;

  assign id_ready       = !ex_stall && !hz && !take;
  assign redirect_valid = take;
  assign id_flush       = take;
  assign redirect_pc    = ex_pc_reg + ex_imm_reg;

  assign alu_a         = (ex_a_sel_reg == A_SEL_IMM) ? ex_imm_reg : fwd_rk;
  assign alu_b         = (ex_b_sel_reg == B_SEL_PC) ? ex_pc_reg : fwd_rj;
  assign alu_op        = ex_op_reg;
  assign ex_store_data = fwd_rk;
  assign ex_valid      = ex_valid_reg;
  assign ex_wen        = ex_wen_reg;
  assign ex_is_load    = ex_is_load_reg;
  assign ex_rd         = ex_rd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_pc_reg        <= '0;
      ex_imm_reg       <= '0;
      ex_rj_data_reg   <= '0;
      ex_rk_data_reg   <= '0;
      ex_rj_reg        <= '0;
      ex_rk_reg        <= '0;
      ex_rd_reg        <= '0;
      ex_op_reg        <= '0;
      ex_a_sel_reg     <= A_SEL_RK;
      ex_b_sel_reg     <= B_SEL_RJ;
      ex_wen_reg       <= 1'b0;
      ex_is_load_reg   <= 1'b0;
      ex_is_branch_reg <= 1'b0;
    end else if (ex_stall) begin
      ex_valid_reg <= ex_valid_reg;
    end else if (take || hz) begin
      ex_valid_reg <= 1'b0;
    end else begin
      ex_valid_reg     <= id_valid;
      ex_pc_reg        <= id_pc;
      ex_imm_reg       <= id_imm;
      ex_rj_data_reg   <= id_rj_data;
      ex_rk_data_reg   <= id_rk_data;
      ex_rj_reg        <= id_rj;
      ex_rk_reg        <= id_rk;
      ex_rd_reg        <= id_rd;
      ex_op_reg        <= id_alu_op;
      ex_a_sel_reg     <= a_sel_e'(id_a_sel);
      ex_b_sel_reg     <= b_sel_e'(id_b_sel);
      ex_wen_reg       <= id_wen;
      ex_is_load_reg   <= id_is_load;
      ex_is_branch_reg <= id_is_branch;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: EX hand-offs are checked against a
// scoreboard queue, control signals are checked cycle by cycle.
module tb_ex_issue_stage;
  import ex_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rj_data, id_rk_data, id_imm;
  logic [4:0]  id_rj, id_rk, id_rd;
  logic        id_use_rj, id_use_rk;
  logic [3:0]  id_alu_op;
  logic        id_a_sel, id_b_sel, id_wen, id_is_load, id_is_branch;
  logic        ex_stall;
  logic        exm_wen, mwb_wen;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_f;
  logic        ex_valid, ex_wen, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_flush;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  ex_issue_stage #(.XLEN(32), .RIDX(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rj_data(id_rj_data), .id_rk_data(id_rk_data), .id_imm(id_imm),
    .id_rj(id_rj), .id_rk(id_rk), .id_rd(id_rd),
    .id_use_rj(id_use_rj), .id_use_rk(id_use_rk), .id_alu_op(id_alu_op),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .ex_stall(ex_stall),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_flush(id_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rj_data = 0; id_rk_data = 0; id_imm = 0;
    id_rj = 0; id_rk = 0; id_rd = 0; id_use_rj = 0; id_use_rk = 0;
    id_alu_op = 0; id_a_sel = 0; id_b_sel = 0;
    id_wen = 0; id_is_load = 0; id_is_branch = 0;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    exm_wen = ew; exm_rd = erd; exm_data = ed;
    mwb_wen = mw; mwb_rd = mrd; mwb_data = md;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] rjd, input logic [31:0] rkd,
                        input logic [31:0] imm, input logic [4:0] rj, input logic [4:0] rk,
                        input logic [4:0] rd, input logic [3:0] op, input logic asel,
                        input logic bsel, input logic wen, input logic ld, input logic br);
    id_valid = 1; id_pc = pc; id_rj_data = rjd; id_rk_data = rkd; id_imm = imm;
    id_rj = rj; id_rk = rk; id_rd = rd; id_use_rj = 1; id_use_rk = 1;
    id_alu_op = op; id_a_sel = asel; id_b_sel = bsel;
    id_wen = wen; id_is_load = ld; id_is_branch = br;
  endtask

  task automatic expect_ex(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [4:0] rd, input logic redir, input logic [31:0] rpc);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.redir = redir; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // An instruction leaves EX whenever it is valid and not held.
  always @(negedge clk) begin
    if (!rst && ex_valid && !ex_stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ex_handoff", 32'(ex_rd), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("ex handoff rd=%0d op=%0d a=0x%08h b=0x%08h redir=%0b", ex_rd, alu_op, alu_a, alu_b,
                 redirect_valid);
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_op", 32'(alu_op), 32'(e.op));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.redir));
        if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; ex_stall = 0; alu_f = 0;
    clear_id();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_redirect", 32'(redirect_valid), 0);
    chk("rst_id_flush", 32'(id_flush), 0);
    next_cycle();
    rst = 0;

    // add.w r3,r1,r2: exm beats mwb on rj, rk from RF
    set_id(32'h1C00_0000, 32'h99, 32'h5, 0, 1, 2, 3, OP_ADD, A_SEL_RK, B_SEL_RJ, 1, 0, 0);
    expect_ex(32'h5, 32'h10, OP_ADD, 3, 0, 0);
    @(negedge clk); chk("add_id_ready", 32'(id_ready), 1);
    next_cycle();
    set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
    // r0 source reads zero even with exm_rd=0; rk=r7 from mwb
    set_id(32'h1C00_0004, 32'h1234, 32'h77, 0, 0, 7, 8, OP_OR, A_SEL_RK, B_SEL_RJ, 1, 0, 0);
    expect_ex(32'h700, 32'h0, OP_OR, 8, 0, 0);
    @(negedge clk); chk("add_store_data", ex_store_data, 32'h5);
    next_cycle();
    set_fwd(1, 0, 32'hFFFF, 1, 7, 32'h700);
    // imm/pc operand selects
    set_id(32'h1C00_0008, 32'h1, 32'h2, 32'h44, 1, 2, 9, OP_SUB, A_SEL_IMM, B_SEL_PC, 1, 0, 0);
    expect_ex(32'h44, 32'h1C00_0008, OP_SUB, 9, 0, 0);
    next_cycle();
    set_fwd(0, 0, 0, 0, 0, 0);
    clear_id();
    next_cycle();

    // Load-use: ld.w r4 then add r5,r4,r6
    set_id(32'h1C00_0010, 32'h100, 32'h0, 32'h8, 1, 0, 4, OP_ADD, A_SEL_IMM, B_SEL_RJ, 1, 1, 0);
    expect_ex(32'h8, 32'h100, OP_ADD, 4, 0, 0);
    next_cycle();
    set_id(32'h1C00_0014, 32'hDEAD, 32'h66, 0, 4, 6, 5, OP_ADD, A_SEL_RK, B_SEL_RJ, 1, 0, 0);
    expect_ex(32'h66, 32'hABCD, OP_ADD, 5, 0, 0);
    @(negedge clk);
    chk("lu_id_ready", 32'(id_ready), 0);
    chk("lu_ex_is_load", 32'(ex_is_load), 1);
    next_cycle();
    @(negedge clk);
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_id_ready_after", 32'(id_ready), 1);
    next_cycle();
    clear_id();
    set_fwd(1, 4, 32'hABCD, 0, 0, 0);
    next_cycle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Taken beq: redirect, flush, ID instruction dropped
    set_id(32'h1C00_0010, 0, 0, 32'h20, 0, 0, 0, OP_BEQ, A_SEL_RK, B_SEL_RJ, 0, 0, 1);
    expect_ex(0, 0, OP_BEQ, 0, 1, 32'h1C00_0030);
    next_cycle();
    alu_f = 1;
    set_id(32'h1C00_0014, 1, 2, 0, 1, 2, 10, OP_ADD, A_SEL_RK, B_SEL_RJ, 1, 0, 0);
    @(negedge clk);
    chk("br_redirect", 32'(redirect_valid), 1);
    chk("br_redirect_pc", redirect_pc, 32'h1C00_0030);
    chk("br_id_flush", 32'(id_flush), 1);
    chk("br_id_ready", 32'(id_ready), 0);
    next_cycle();
    alu_f = 0;
    clear_id();
    @(negedge clk);
    chk("br_ex_valid_after", 32'(ex_valid), 0);
    chk("br_redirect_after", 32'(redirect_valid), 0);
    next_cycle();

    // Not-taken beq: ID instruction captured behind it
    set_id(32'h1C00_0100, 0, 0, 32'h40, 0, 0, 0, OP_BEQ, A_SEL_RK, B_SEL_RJ, 0, 0, 1);
    expect_ex(0, 0, OP_BEQ, 0, 0, 0);
    next_cycle();
    set_id(32'h200, 0, 0, 32'h5, 0, 0, 11, OP_AND, A_SEL_IMM, B_SEL_PC, 1, 0, 0);
    expect_ex(32'h5, 32'h200, OP_AND, 11, 0, 0);
    @(negedge clk);
    chk("nt_id_ready", 32'(id_ready), 1);
    chk("nt_redirect", 32'(redirect_valid), 0);
    next_cycle();
    clear_id();
    @(negedge clk);
    chk("nt_captured", 32'(ex_valid), 1);
    next_cycle();

    // Taken branch held by ex_stall for 3 cycles; target wraps past 2^32
    set_id(32'hFFFF_FFF0, 0, 0, 32'h20, 0, 0, 0, OP_BEQ, A_SEL_RK, B_SEL_RJ, 0, 0, 1);
    expect_ex(0, 0, OP_BEQ, 0, 1, 32'h10);
    next_cycle();
    alu_f = 1; ex_stall = 1;
    set_id(32'h300, 0, 0, 0, 0, 0, 12, OP_ADD, A_SEL_RK, B_SEL_RJ, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_redirect", 32'(redirect_valid), 0);
      chk("stall_id_flush", 32'(id_flush), 0);
      chk("stall_id_ready", 32'(id_ready), 0);
      chk("stall_ex_valid", 32'(ex_valid), 1);
      chk("stall_alu_op", 32'(alu_op), 32'(OP_BEQ));
      next_cycle();
    end
    ex_stall = 0;
    @(negedge clk);
    chk("stall_release_redirect", 32'(redirect_valid), 1);
    next_cycle();
    alu_f = 0;
    clear_id();
    @(negedge clk);
    chk("stall_once_redirect", 32'(redirect_valid), 0);
    chk("stall_once_ex_valid", 32'(ex_valid), 0);
    next_cycle();

    // Async reset in the middle of a redirect
    set_id(32'h1C00_0010, 0, 0, 32'h20, 0, 0, 0, OP_BEQ, A_SEL_RK, B_SEL_RJ, 0, 0, 1);
    next_cycle();
    alu_f = 1;
    clear_id();
    #1;
    chk("pre_rst_redirect", 32'(redirect_valid), 1);
    #1 rst = 1;
    #1;
    chk("async_rst_redirect", 32'(redirect_valid), 0);
    chk("async_rst_ex_valid", 32'(ex_valid), 0);
    chk("async_rst_flush", 32'(id_flush), 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("post_rst_ex_valid", 32'(ex_valid), 0);
    chk("post_rst_redirect", 32'(redirect_valid), 0);
    next_cycle();
    alu_f = 0;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
